passcode_lock_ctrl: RTL and testbench
=====================================

# passcode_lock_ctrl

Parametrised passcode entry and lock controller: digits are keyed in from `switch`, one per `enter` press, shown on the seven-segment bus, then compared against a stored code. It adds a retry limit with timed lockout and an in-field code change with confirmation. It sits between the board button/switch inputs and the display/LED drivers, and replaces the fixed four-digit entry sequencer.

## Interface

- `DIGITS`, 4: number of code digits and display positions (1–8).
- `DIGIT_W`, 4: bits per digit (1–4).
- `DEFAULT_CODE`, 16'h1234: code loaded at reset, width `DIGITS*DIGIT_W`; digit `DIGITS-1` is in the MS bits.
- `MAX_TRIES`, 3: wrong attempts allowed before lockout (1–15).
- `LOCKOUT_CYCLES`, 50_000_000: lockout duration in clocks (≥1).

Ports:

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `switch`  in  `DIGIT_W`  digit value, sampled on an `enter` rise.
- `enter`  in  1  debounced, synchronous button.
- `clear`  in  1  debounced, synchronous button.
- `change`  in  1  debounced, synchronous button.
- `ssd`  out  `7*DIGITS`  segments.
  - Digit i occupies `[7i+6:7i]`, with bit order a..g from LSB.
  - Segments are active-low.
  - Digit `DIGITS-1` is the leftmost position.
- `led`  out  8  status outputs.
  - [0] OPEN
  - [1] FAIL
  - [2] LOCKOUT
  - [3] NEW or CONFIRM
  - [7:4] tries remaining

## Operation

- Button handling:
  - Each button is registered once.
  - An action fires on `btn & ~btn_q`, i.e. one action per 0→1 transition.
  - `btn_q` resets to 1, so a button held through reset release is ignored.
- Priority when rises coincide: `clear` > `change` > `enter`. Only the highest-priority rise acts.
- Entry buffer `buf` (`DIGITS` digits) and index `idx`:
  - An `enter` rise in an entry state writes `switch` to digit `DIGITS-1-idx` and increments `idx`.
  - When `idx` reaches `DIGITS`, the state advances and `idx` returns to 0.
- States:
  - LOCKED (reset state)
    - Entry state.
    - When full → CHECK.
    - `clear` zeroes `buf` and `idx`.
    - `change` is ignored.
  - CHECK (1 cycle)
    - `buf == code` → OPEN, tries := `MAX_TRIES`.
    - Mismatch with tries > 1 → FAIL, tries decremented.
    - Mismatch with tries = 1 → LOCKOUT, tries := 0, timer := `LOCKOUT_CYCLES`.
  - FAIL
    - Any `enter` or `clear` rise → LOCKED with `buf` cleared. That digit is not captured.
  - LOCKOUT
    - All buttons are ignored.
    - The timer decrements each cycle.
    - At timer 1 → LOCKED, tries := `MAX_TRIES`.
  - OPEN
    - `enter` → LOCKED (relock).
    - `change` → NEW.
  - NEW
    - Entry state.
    - When full → copy `buf` to `pend`, then → CONFIRM.
    - `clear` → OPEN.
  - CONFIRM
    - Entry state.
    - When full: `buf == pend` → code := `pend`; otherwise the code is unchanged. Either way → OPEN.
    - `clear` → OPEN.
- `buf` is cleared on every state entry.
- Display:
  - In entry states, captured positions show the digit in hex. Uncaptured positions show dash (7'b0111111).
  - OPEN: all positions show 0.
  - FAIL: all positions show dash.
  - LOCKOUT: all positions blank (7'b1111111).
- `led[7:4]` = tries, zero-extended.
- `switch` values above 9 are valid digits.

## Timing

- All outputs are registered.
- Reset values:
  - state LOCKED, code `DEFAULT_CODE`.
  - `ssd` all dash.
  - `led` = {MAX_TRIES[3:0], 4'b0000}.
- An input rise at edge k is detected at edge k+1 and acted on at that edge. `ssd`/`led` reflect the result at edge k+2.
- Final digit captured at cycle N:
  - CHECK at N+1.
  - OPEN, FAIL or LOCKOUT at N+2.
  - Outputs visible at N+3.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` clocks.
- Asserting `reset` mid-operation forces reset values immediately, including `code`. A changed code is lost.

## Configuration

- `PASSCODE_MASK_EN`
  - Defined: captured digits in LOCKED, NEW and CONFIRM display as underscore (segment d only, 7'b1110111) instead of hex. OPEN still shows 0s.
  - Undefined: captured digits display in hex.

## Test plan

All scenarios use `DIGITS`=4, `DIGIT_W`=4, `DEFAULT_CODE`=16'h1234, `MAX_TRIES`=3, `LOCKOUT_CYCLES`=16, without `PASSCODE_MASK_EN` unless stated.

- **Correct code:** enter 1,2,3,4 → `led[0]`=1, `led[7:4]`=3, `ssd` all 0s 3 cycles after the last rise. Then an `enter` rise → LOCKED, `ssd` all dash.
- **Retry and lockout:**
  - Enter 1,2,3,5 → `led[1]`=1, `led[7:4]`=2.
  - Enter `clear`, then 5,5,5,5 → `led[1]`=1, `led[7:4]`=1.
  - Enter `clear`, then 5,5,5,5 → `led[2]`=1, `ssd` blank, buttons ignored for 16 cycles, then LOCKED with `led[7:4]`=3.
- **Clear and simultaneous rises:**
  - Enter 1,2, then `clear` → leftmost two digits return to dash and `idx`=0.
  - `clear`+`enter` rising together → no digit captured.
- **Code change:**
  - From OPEN: `change`, enter 9,8,7,6, confirm 9,8,7,6 → OPEN.
  - Relock; 1,2,3,4 now fails; 9,8,7,6 opens.
  - Mismatched confirm 9,8,7,5 leaves the code 1234.
- **Reset:**
  - Assert `reset` low mid-entry and after a code change → outputs return to reset values asynchronously; the code is 1234 again.
  - `enter` held high across reset release → no capture.
- **`PASSCODE_MASK_EN` defined:** enter 1,2 → leftmost two positions show 7'b1110111, remaining positions dash.

Source files
------------

// File: rtl/passcode_lock_ctrl.sv
// Passcode entry/lock controller: digit entry, retry limit with timed lockout, in-field code change.
// Optional `PASSCODE_MASK_EN` shows captured entry digits as underscores instead of hex.
module passcode_lock_ctrl #(
    parameter int                       DIGITS         = 4,
    parameter int                       DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE  = 16'h1234,
    parameter int                       MAX_TRIES      = 3,
    parameter int                       LOCKOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGIT_W-1:0]    switch,
    input  logic                  enter,
    input  logic                  clear,
    input  logic                  change,
    output logic [7*DIGITS-1:0]   ssd,
    output logic [7:0]            led
);
    localparam int CW    = DIGITS * DIGIT_W;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [2:0] {
        S_LOCKED, S_CHECK, S_FAIL, S_LOCKOUT, S_OPEN, S_NEW, S_CONFIRM
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      entry_q, pend_q, code_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         tries_q;
    logic [TMR_W-1:0]   timer_q;
    logic [2:0]         btn_q;
    logic [7*DIGITS-1:0] ssd_q, ssd_d;
    logic [7:0]         led_q, led_d;
    logic [CW-1:0]      entry_cap;

    logic [2:0] rise;
    logic       clr_act, chg_act, ent_act, full;

    assign rise    = {clear, change, enter} & ~btn_q;
    assign clr_act = rise[2];
    assign chg_act = rise[1] & ~rise[2];
    assign ent_act = rise[0] & ~rise[1] & ~rise[2];
    assign full    = (idx_q == IDX_W'(DIGITS));

`ifndef PASSCODE_MASK_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction
`endif

    // Per-position capture mux and display decode; digit DIGITS-1 is filled first.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [6:0] ent_seg;
        logic       captured;

        assign entry_cap[gi*DIGIT_W +: DIGIT_W] = (idx_q == IDX_W'(DIGITS-1-gi)) ?
                                                  switch : entry_q[gi*DIGIT_W +: DIGIT_W];
        assign captured = (int'(idx_q) > DIGITS-1-gi);
`ifdef PASSCODE_MASK_EN
        assign ent_seg = 7'b1110111;
`else
        assign ent_seg = hex7(4'(entry_q[gi*DIGIT_W +: DIGIT_W]));
`endif
        assign ssd_d[gi*7 +: 7] = (state_q == S_OPEN)    ? SEG_ZERO  :
                                  (state_q == S_FAIL)    ? SEG_DASH  :
                                  (state_q == S_LOCKOUT) ? SEG_BLANK :
                                  (state_q == S_CHECK || captured) ? ent_seg : SEG_DASH;
    end

    assign led_d = {tries_q,
                    (state_q == S_NEW) || (state_q == S_CONFIRM),
                    state_q == S_LOCKOUT,
                    state_q == S_FAIL,
                    state_q == S_OPEN};

    assign ssd = ssd_q;
    assign led = led_q;

    // A full buffer is acted on one cycle after the final capture, ahead of any button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOCKED;
            entry_q <= '0;
            pend_q  <= '0;
            code_q  <= DEFAULT_CODE;
            idx_q   <= '0;
            tries_q <= 4'(MAX_TRIES);
            timer_q <= '0;
            btn_q   <= 3'b111;
            ssd_q   <= {DIGITS{SEG_DASH}};
            led_q   <= {4'(MAX_TRIES), 4'b0000};
        end else begin
            btn_q <= {clear, change, enter};
            ssd_q <= ssd_d;
            led_q <= led_d;
            case (state_q)
                S_LOCKED: begin
                    if (full) begin
                        state_q <= S_CHECK;
                        idx_q   <= '0;
                    end else if (clr_act) begin
                        entry_q <= '0;
                        idx_q   <= '0;
                    end else if (ent_act) begin
                        entry_q <= entry_cap;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                S_CHECK: begin
                    entry_q <= '0;
                    idx_q   <= '0;
                    if (entry_q == code_q) begin
                        state_q <= S_OPEN;
                        tries_q <= 4'(MAX_TRIES);
                    end else if (tries_q > 4'd1) begin
                        state_q <= S_FAIL;
                        tries_q <= tries_q - 4'd1;
                    end else begin
                        state_q <= S_LOCKOUT;
                        tries_q <= 4'd0;
                        timer_q <= TMR_W'(LOCKOUT_CYCLES);
                    end
                end
                S_FAIL: begin
                    if (clr_act || ent_act) begin
                        state_q <= S_LOCKED;
                        entry_q <= '0;
                        idx_q   <= '0;
                    end
                end
                S_LOCKOUT: begin
                    if (timer_q == TMR_W'(1)) begin
                        state_q <= S_LOCKED;
                        tries_q <= 4'(MAX_TRIES);
                        entry_q <= '0;
                        idx_q   <= '0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                S_OPEN: begin
                    if (chg_act) begin
                        state_q <= S_NEW;
                        entry_q <= '0;
                        idx_q   <= '0;
                    end else if (ent_act) begin
                        state_q <= S_LOCKED;
                        entry_q <= '0;
                        idx_q   <= '0;
                    end
                end
                S_NEW, S_CONFIRM: begin
                    if (full) begin
                        if (state_q == S_NEW) begin
                            pend_q  <= entry_q;
                            state_q <= S_CONFIRM;
                        end else begin
                            if (entry_q == pend_q) code_q <= pend_q;
                            state_q <= S_OPEN;
                        end
                        entry_q <= '0;
                        idx_q   <= '0;
                    end else if (clr_act) begin
                        state_q <= S_OPEN;
                        entry_q <= '0;
                        idx_q   <= '0;
                    end else if (ent_act) begin
                        entry_q <= entry_cap;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= S_LOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl with LOCKOUT_CYCLES=16; honours PASSCODE_MASK_EN for entry-digit glyphs.
module tb_passcode_lock_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  switch = 4'h0;
    logic        enter = 1'b0, clear = 1'b0, change = 1'b0;
    logic [27:0] ssd;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] ZERO  = 7'h40;
`ifdef PASSCODE_MASK_EN
    localparam logic [6:0] E1 = 7'h77, E2 = 7'h77, E9 = 7'h77;
`else
    localparam logic [6:0] E1 = 7'h79, E2 = 7'h24, E9 = 7'h10;
`endif

    passcode_lock_ctrl #(
        .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234),
        .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .switch(switch), .enter(enter),
        .clear(clear), .change(change), .ssd(ssd), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        switch = d;
        enter  = 1'b1;
        tick(1);
        enter  = 1'b0;
        tick(1);
        $display("press enter switch=%h led=%h", d, led);
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        $display("press clear led=%h", led);
    endtask

    task automatic pulse_change;
        change = 1'b1;
        tick(1);
        change = 1'b0;
        tick(1);
        $display("press change led=%h", led);
    endtask

    task automatic enter_code(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    task automatic test_reset;
        #12;
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL reset_ssd got %h want %h", ssd, {4{DASH}}); end
        checks++; if (led !== 8'h30) begin errors++; $display("FAIL reset_led got %h want %h", led, 8'h30); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_correct_code;
        enter_code(16'h1234);
        tick(1);
        checks++; if (led !== 8'h30) begin errors++; $display("FAIL open_early got %h want %h", led, 8'h30); end
        tick(1);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL open_led got %h want %h", led, 8'h31); end
        checks++; if (ssd !== {4{ZERO}}) begin errors++; $display("FAIL open_ssd got %h want %h", ssd, {4{ZERO}}); end
        press(4'h0);
        checks++; if (led !== 8'h30) begin errors++; $display("FAIL relock_led got %h want %h", led, 8'h30); end
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL relock_ssd got %h want %h", ssd, {4{DASH}}); end
    endtask

    task automatic test_clear;
        press(4'h1);
        checks++; if (ssd !== {E1, DASH, DASH, DASH}) begin errors++; $display("FAIL entry1_ssd got %h want %h", ssd, {E1, DASH, DASH, DASH}); end
        press(4'h2);
        checks++; if (ssd !== {E1, E2, DASH, DASH}) begin errors++; $display("FAIL entry2_ssd got %h want %h", ssd, {E1, E2, DASH, DASH}); end
        pulse_clear();
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL clear_ssd got %h want %h", ssd, {4{DASH}}); end
        switch = 4'h7;
        clear  = 1'b1;
        enter  = 1'b1;
        tick(1);
        clear  = 1'b0;
        enter  = 1'b0;
        tick(1);
        $display("press clear+enter together led=%h", led);
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL simul_ssd got %h want %h", ssd, {4{DASH}}); end
        enter_code(16'h1234);
        tick(2);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL after_clear_open got %h want %h", led, 8'h31); end
        press(4'h0);
    endtask

    task automatic test_retry_lockout;
        enter_code(16'h1235);
        tick(2);
        checks++; if (led !== 8'h22) begin errors++; $display("FAIL fail1_led got %h want %h", led, 8'h22); end
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL fail1_ssd got %h want %h", ssd, {4{DASH}}); end
        pulse_clear();
        checks++; if (led !== 8'h20) begin errors++; $display("FAIL fail1_clear got %h want %h", led, 8'h20); end
        enter_code(16'h5555);
        tick(2);
        checks++; if (led !== 8'h12) begin errors++; $display("FAIL fail2_led got %h want %h", led, 8'h12); end
        pulse_clear();
        enter_code(16'h5555);
        tick(2);
        checks++; if (led !== 8'h04) begin errors++; $display("FAIL lockout_led got %h want %h", led, 8'h04); end
        checks++; if (ssd !== {4{BLANK}}) begin errors++; $display("FAIL lockout_ssd got %h want %h", ssd, {4{BLANK}}); end
        press(4'h1);
        tick(13);
        checks++; if (led !== 8'h04) begin errors++; $display("FAIL lockout_end_early got %h want %h", led, 8'h04); end
        tick(1);
        checks++; if (led !== 8'h30) begin errors++; $display("FAIL lockout_exit_led got %h want %h", led, 8'h30); end
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL lockout_exit_ssd got %h want %h", ssd, {4{DASH}}); end
    endtask

    task automatic test_code_change;
        enter_code(16'h1234);
        tick(2);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL chg_open got %h want %h", led, 8'h31); end
        pulse_change();
        checks++; if (led !== 8'h38) begin errors++; $display("FAIL new_led got %h want %h", led, 8'h38); end
        press(4'h9);
        checks++; if (ssd[27:21] !== E9) begin errors++; $display("FAIL new_digit got %h want %h", ssd[27:21], E9); end
        press(4'h8);
        press(4'h7);
        press(4'h6);
        tick(1);
        checks++; if (led !== 8'h38) begin errors++; $display("FAIL confirm_led got %h want %h", led, 8'h38); end
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL confirm_ssd got %h want %h", ssd, {4{DASH}}); end
        enter_code(16'h9876);
        tick(1);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL confirm_open got %h want %h", led, 8'h31); end
        press(4'h0);
        enter_code(16'h1234);
        tick(2);
        checks++; if (led !== 8'h22) begin errors++; $display("FAIL old_code_fails got %h want %h", led, 8'h22); end
        pulse_clear();
        enter_code(16'h9876);
        tick(2);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL new_code_opens got %h want %h", led, 8'h31); end
    endtask

    task automatic test_async_reset;
        press(4'h0);
        press(4'h9);
        press(4'h8);
        #2 reset = 1'b0;
        #1;
        $display("reset asserted mid-entry led=%h", led);
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL async_rst_ssd got %h want %h", ssd, {4{DASH}}); end
        checks++; if (led !== 8'h30) begin errors++; $display("FAIL async_rst_led got %h want %h", led, 8'h30); end
        switch = 4'h5;
        enter  = 1'b1;
        #3 reset = 1'b1;
        tick(2);
        enter  = 1'b0;
        tick(2);
        $display("reset released with enter held led=%h", led);
        checks++; if (ssd !== {4{DASH}}) begin errors++; $display("FAIL held_enter_ssd got %h want %h", ssd, {4{DASH}}); end
        enter_code(16'h1234);
        tick(2);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL code_restored got %h want %h", led, 8'h31); end
    endtask

    task automatic test_mismatch_confirm;
        pulse_change();
        enter_code(16'h9876);
        tick(1);
        enter_code(16'h9875);
        tick(1);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL mismatch_open got %h want %h", led, 8'h31); end
        press(4'h0);
        enter_code(16'h9876);
        tick(2);
        checks++; if (led !== 8'h22) begin errors++; $display("FAIL unconfirmed_fails got %h want %h", led, 8'h22); end
        pulse_clear();
        enter_code(16'h1234);
        tick(2);
        checks++; if (led !== 8'h31) begin errors++; $display("FAIL code_kept got %h want %h", led, 8'h31); end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_clear();
        test_retry_lockout();
        test_code_change();
        test_async_reset();
        test_mismatch_confirm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
